// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Width helpers and the registered handshake-status type shared
//               by fifo_prog_thresh and its assertion checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  typedef struct packed {
    logic wr_ack;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

`default_nettype wire

// File: rtl/fifo_prog_thresh_sva.sv
// ============================================================================
// Module      : fifo_prog_thresh_sva
// Description : Passive protocol checker for fifo_prog_thresh; every property
//               has a companion cover. Instantiated when FIFO_ASSERT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_prog_thresh_sva
  import fifo_pkg::*;
#(
  parameter  int FIFO_WIDTH = 16,
  parameter  int FIFO_DEPTH = 8,
  localparam int CW         = cnt_w(FIFO_DEPTH)
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic [FIFO_WIDTH-1:0] data_in,
  input logic                  wr_en,
  input logic                  rd_en,
  input logic [CW-1:0]         af_thresh,
  input logic [CW-1:0]         ae_thresh,
  input logic                  hwm_clr,
  input logic [FIFO_WIDTH-1:0] data_out,
  input logic                  wr_ack,
  input logic                  overflow,
  input logic                  underflow,
  input logic                  full,
  input logic                  empty,
  input logic                  almostfull,
  input logic                  almostempty,
  input logic [CW-1:0]         count,
  input logic [CW-1:0]         hwm
);

  localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);

  a_full:  assert property (@(posedge clk) disable iff (!rst_n) full == (count == C_DEPTH));
  a_empty: assert property (@(posedge clk) disable iff (!rst_n) empty == (count == '0));
  a_af:    assert property (@(posedge clk) disable iff (!rst_n)
                            almostfull == ((count >= af_thresh) && !full));
  a_ae:    assert property (@(posedge clk) disable iff (!rst_n)
                            almostempty == ((count <= ae_thresh) && !empty));
  a_ovf:   assert property (@(posedge clk) disable iff (!rst_n) (full && wr_en) |=> overflow);
  a_udf:   assert property (@(posedge clk) disable iff (!rst_n) (empty && rd_en) |=> underflow);
  a_range: assert property (@(posedge clk) disable iff (!rst_n) count <= C_DEPTH);
  a_step:  assert property (@(posedge clk) disable iff (!rst_n)
                            (count == $past(count)) || (count == $past(count) + CW'(1)) ||
                            (count == $past(count) - CW'(1)));
  a_hwm:   assert property (@(posedge clk) disable iff (!rst_n) hwm >= count);
  a_clr:   assert property (@(posedge clk) disable iff (!rst_n) hwm_clr |=> (hwm == count));
  a_hold:  assert property (@(posedge clk) disable iff (!rst_n)
                            !(rd_en && !empty) |=> $stable(data_out));
  a_ack:   assert property (@(posedge clk) disable iff (!rst_n)
                            (wr_en && !full) |=> (wr_ack && !$isunknown($past(data_in))));

  c_full:  cover property (@(posedge clk) disable iff (!rst_n) full);
  c_empty: cover property (@(posedge clk) disable iff (!rst_n) empty && wr_en);
  c_af:    cover property (@(posedge clk) disable iff (!rst_n) almostfull);
  c_ae:    cover property (@(posedge clk) disable iff (!rst_n) almostempty);
  c_ovf:   cover property (@(posedge clk) disable iff (!rst_n) (full && wr_en) ##1 overflow);
  c_udf:   cover property (@(posedge clk) disable iff (!rst_n) (empty && rd_en) ##1 underflow);
  c_range: cover property (@(posedge clk) disable iff (!rst_n) count == C_DEPTH);
  c_step:  cover property (@(posedge clk) disable iff (!rst_n) count != $past(count));
  c_hwm:   cover property (@(posedge clk) disable iff (!rst_n) hwm > count);
  c_clr:   cover property (@(posedge clk) disable iff (!rst_n) hwm_clr ##1 (hwm == count));
  c_hold:  cover property (@(posedge clk) disable iff (!rst_n) rd_en && empty);
  c_ack:   cover property (@(posedge clk) disable iff (!rst_n) wr_ack);

endmodule

`default_nettype wire

// File: rtl/fifo_prog_thresh.sv
// ============================================================================
// Module      : fifo_prog_thresh
// Description : Synchronous FIFO (any depth >= 2) with run-time almost-full /
//               almost-empty thresholds, registered handshake status and a
//               clearable high-water mark. Define FIFO_ASSERT_EN to embed
//               the fifo_prog_thresh_sva checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_prog_thresh
  import fifo_pkg::*;
#(
  parameter  int FIFO_WIDTH = 16,
  parameter  int FIFO_DEPTH = 8,
  localparam int CW         = cnt_w(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [CW-1:0]         af_thresh,
  input  logic [CW-1:0]         ae_thresh,
  input  logic                  hwm_clr,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CW-1:0]         count,
  output logic [CW-1:0]         hwm
);

  localparam int              PW      = ptr_w(FIFO_DEPTH);
  localparam logic [CW-1:0]   C_DEPTH = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0]   C_LAST  = PW'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d, hwm_q, hwm_d;
  logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
  fifo_status_t          status_q, status_d;
  logic                  wr_accept, rd_accept;

  assign full        = (count_q == C_DEPTH);
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= af_thresh) && !full;
  assign almostempty = (count_q <= ae_thresh) && !empty;
  assign wr_accept   = wr_en && !full;
  assign rd_accept   = rd_en && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    status_d   = '{wr_ack: wr_accept, overflow: wr_en && full, underflow: rd_en && empty};

    // Explicit wrap keeps non-power-of-two depths inside the array.
    if (wr_accept) wr_ptr_d = (wr_ptr_q == C_LAST) ? '0 : wr_ptr_q + PW'(1);
    if (rd_accept) begin
      rd_ptr_d   = (rd_ptr_q == C_LAST) ? '0 : rd_ptr_q + PW'(1);
      data_out_d = mem_q[rd_ptr_q];
    end

    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (hwm_clr || (count_d > hwm_q)) hwm_d = count_d;
    else                              hwm_d = hwm_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hwm_q      <= '0;
      data_out_q <= '0;
      status_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hwm_q      <= hwm_d;
      data_out_q <= data_out_d;
      status_q   <= status_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out  = data_out_q;
  assign wr_ack    = status_q.wr_ack;
  assign overflow  = status_q.overflow;
  assign underflow = status_q.underflow;
  assign count     = count_q;
  assign hwm       = hwm_q;

`ifdef FIFO_ASSERT_EN
  fifo_prog_thresh_sva #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_sva (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .af_thresh   (af_thresh),
    .ae_thresh   (ae_thresh),
    .hwm_clr     (hwm_clr),
    .data_out    (data_out),
    .wr_ack      (wr_ack),
    .overflow    (overflow),
    .underflow   (underflow),
    .full        (full),
    .empty       (empty),
    .almostfull  (almostfull),
    .almostempty (almostempty),
    .count       (count),
    .hwm         (hwm)
  );
`else
  // Checker not built; datapath is identical either way.
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_prog_thresh.sv
// ============================================================================
// Module      : tb_fifo_prog_thresh
// Description : Directed scoreboard bench for fifo_prog_thresh at depth 8
//               and depth 5 (pointer wrap on a non-power-of-two depth).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fifo_prog_thresh;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] din8, dout8, din5, dout5;
  logic        wr8, rd8, hclr8, wr5, rd5, hclr5;
  logic [3:0]  af8, ae8, af5, ae5, cnt8, hwm8, cnt5, hwm5;
  logic        ack8, ovf8, udf8, full8, empty8, afl8, ael8;
  logic        ack5, ovf5, udf5, full5, empty5, afl5, ael5;

  fifo_prog_thresh #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .data_in(din8), .wr_en(wr8), .rd_en(rd8),
    .af_thresh(af8), .ae_thresh(ae8), .hwm_clr(hclr8), .data_out(dout8),
    .wr_ack(ack8), .overflow(ovf8), .underflow(udf8), .full(full8), .empty(empty8),
    .almostfull(afl8), .almostempty(ael8), .count(cnt8), .hwm(hwm8));

  fifo_prog_thresh #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) u_d5 (
    .clk(clk), .rst_n(rst_n), .data_in(din5), .wr_en(wr5), .rd_en(rd5),
    .af_thresh(af5), .ae_thresh(ae5), .hwm_clr(hclr5), .data_out(dout5),
    .wr_ack(ack5), .overflow(ovf5), .underflow(udf5), .full(full5), .empty(empty5),
    .almostfull(afl5), .almostempty(ael5), .count(cnt5), .hwm(hwm5));

  typedef struct packed {
    logic [2:0]  st;    // {wr_ack, overflow, underflow}
    logic [15:0] dout;
    logic [3:0]  cnt;
    logic [3:0]  flg;   // {full, empty, almostfull, almostempty}
    logic [3:0]  hwm;
  } obs_t;

  typedef struct packed {
    logic sel;          // 0: depth-8 instance, 1: depth-5 instance
    obs_t o;
  } exp_t;

  exp_t sbq[$];
  event chk_ev;
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic logic [3:0] flags(input int c, input int depth, input int af, input int ae);
    return {c == depth, c == 0, (c >= af) && (c != depth), (c <= ae) && (c != 0)};
  endfunction

  // Monitor: compares on every falling edge with a pending expectation, or on demand.
  always begin
    exp_t e;
    obs_t act;
    @(negedge clk or chk_ev);
    if (sbq.size() > 0) begin
      e   = sbq.pop_front();
      act = e.sel ? {ack5, ovf5, udf5, dout5, cnt5, {full5, empty5, afl5, ael5}, hwm5}
                  : {ack8, ovf8, udf8, dout8, cnt8, {full8, empty8, afl8, ael8}, hwm8};
      n_assert++;
      if (act !== e.o) begin
        n_fail++;
        $display("FAIL sb#%0d dut%0d t=%0t: got st=%b dout=%h cnt=%0d flg=%b hwm=%0d, required st=%b dout=%h cnt=%0d flg=%b hwm=%0d",
                 n_assert, e.sel ? 5 : 8, $time, act.st, act.dout, act.cnt, act.flg, act.hwm,
                 e.o.st, e.o.dout, e.o.cnt, e.o.flg, e.o.hwm);
      end
    end
  end

  // Reset-state check while rst_n is held low after the first rising edge.
  initial begin
    #7;
    n_assert++;
    if ((cnt8 !== 4'd0) || (hwm8 !== 4'd0) || (dout8 !== 16'h0000) ||
        ({ack8, ovf8, udf8} !== 3'b000) || ({full8, empty8, afl8, ael8} !== 4'b0100) ||
        (cnt5 !== 4'd0) || (hwm5 !== 4'd0) || (dout5 !== 16'h0000) ||
        ({ack5, ovf5, udf5} !== 3'b000) || ({full5, empty5, afl5, ael5} !== 4'b0100)) begin
      n_fail++;
      $display("FAIL reset state t=%0t: dut8 cnt=%0d hwm=%0d dout=%h st=%b flg=%b, dut5 cnt=%0d hwm=%0d dout=%h st=%b flg=%b",
               $time, cnt8, hwm8, dout8, {ack8, ovf8, udf8}, {full8, empty8, afl8, ael8},
               cnt5, hwm5, dout5, {ack5, ovf5, udf5}, {full5, empty5, afl5, ael5});
    end
  end

  // Watchdog: the directed sequence must reach its end within the wait budget.
  initial begin
    #100000;
    n_fail++;
    $display("FAIL timeout t=%0t: test sequence did not complete, %0d expectations pending",
             $time, sbq.size());
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  function automatic exp_t mk(input bit sel, input logic [2:0] st, input logic [15:0] dout,
                              input int cnt, input int hwm);
    exp_t e;
    e.sel    = sel;
    e.o.st   = st;
    e.o.dout = dout;
    e.o.cnt  = 4'(cnt);
    e.o.flg  = sel ? flags(cnt, 5, int'(af5), int'(ae5)) : flags(cnt, 8, int'(af8), int'(ae8));
    e.o.hwm  = 4'(hwm);
    return e;
  endfunction

  // One clock of stimulus; the expectation describes the state after that edge.
  task automatic op(input bit sel, input bit w, input bit r, input bit clr, input logic [15:0] din,
                    input logic [2:0] st, input logic [15:0] dout, input int cnt, input int hwm);
    @(negedge clk); #1;
    if (sel) begin wr5 = w; rd5 = r; din5 = din; end
    else     begin wr8 = w; rd8 = r; din8 = din; hclr8 = clr; end
    @(posedge clk); #1;
    wr8 = 1'b0; rd8 = 1'b0; hclr8 = 1'b0; wr5 = 1'b0; rd5 = 1'b0;
    sbq.push_back(mk(sel, st, dout, cnt, hwm));
  endtask

  task automatic thr(input logic [3:0] af, input logic [3:0] ae);
    @(negedge clk); #1;
    af8 = af; ae8 = ae;
  endtask

  initial begin
    din8 = '0; din5 = '0; wr8 = 0; rd8 = 0; hclr8 = 0; wr5 = 0; rd5 = 0; hclr5 = 0;
    af8 = 4'd6; ae8 = 4'd2; af5 = 4'd4; ae5 = 4'd1;

    #2;
    sbq.push_back(mk(1'b0, 3'b000, 16'h0000, 0, 0));
    sbq.push_back(mk(1'b1, 3'b000, 16'h0000, 0, 0));
    -> chk_ev;
    #1 -> chk_ev;
    #9 rst_n = 1'b1;

    op(0, 0, 0, 0, 16'h0, 3'b000, 16'h0000, 0, 0);
    for (int i = 1; i <= 8; i++) op(0, 1, 0, 0, 16'(i), 3'b100, 16'h0000, i, i);
    repeat (2) op(0, 1, 0, 0, 16'h0009, 3'b010, 16'h0000, 8, 8);
    for (int i = 1; i <= 8; i++) op(0, 0, 1, 0, 16'h0, 3'b000, 16'(i), 8 - i, 8);
    op(0, 0, 1, 0, 16'h0, 3'b001, 16'h0008, 0, 8);

    op(0, 1, 1, 0, 16'h0A0A, 3'b101, 16'h0008, 1, 8);
    op(0, 1, 0, 0, 16'h0B0B, 3'b100, 16'h0008, 2, 8);
    op(0, 1, 0, 0, 16'h0C0C, 3'b100, 16'h0008, 3, 8);
    op(0, 1, 1, 0, 16'h0D0D, 3'b100, 16'h0A0A, 3, 8);
    for (int i = 0; i < 5; i++) op(0, 1, 0, 0, 16'h0E0E + 16'(i) * 16'h0101, 3'b100, 16'h0A0A, 4 + i, 8);
    op(0, 1, 1, 0, 16'h7777, 3'b010, 16'h0B0B, 7, 8);

    op(0, 0, 0, 1, 16'h0, 3'b000, 16'h0B0B, 7, 7);
    for (int i = 0; i < 4; i++) op(0, 0, 1, 0, 16'h0, 3'b000, 16'h0C0C + 16'(i) * 16'h0101, 6 - i, 7);
    op(0, 0, 0, 1, 16'h0, 3'b000, 16'h0F0F, 3, 3);
    op(0, 1, 0, 0, 16'h1313, 3'b100, 16'h0F0F, 4, 4);

    thr(4'd0, 4'd2); op(0, 0, 0, 0, 16'h0, 3'b000, 16'h0F0F, 4, 4);
    thr(4'd4, 4'd4); op(0, 0, 0, 0, 16'h0, 3'b000, 16'h0F0F, 4, 4);
    thr(4'd5, 4'd3); op(0, 0, 0, 0, 16'h0, 3'b000, 16'h0F0F, 4, 4);
    thr(4'd8, 4'd0); op(0, 0, 0, 0, 16'h0, 3'b000, 16'h0F0F, 4, 4);
    thr(4'd6, 4'd2);
    op(0, 1, 0, 0, 16'h1414, 3'b100, 16'h0F0F, 5, 5);

    @(negedge clk); #3;
    rst_n = 1'b0;
    #1;
    sbq.push_back(mk(1'b0, 3'b000, 16'h0000, 0, 0));
    -> chk_ev;
    @(posedge clk); #1;
    rst_n = 1'b1;
    op(0, 1, 0, 0, 16'h5555, 3'b100, 16'h0000, 1, 1);
    op(0, 0, 1, 0, 16'h0, 3'b000, 16'h5555, 0, 1);

    op(1, 1, 0, 0, 16'h0101, 3'b100, 16'h0000, 1, 1);
    op(1, 1, 0, 0, 16'h0102, 3'b100, 16'h0000, 2, 2);
    for (int k = 3; k <= 12; k++) op(1, 1, 1, 0, 16'h0100 + 16'(k), 3'b100, 16'h0100 + 16'(k - 2), 2, 2);
    op(1, 0, 1, 0, 16'h0, 3'b000, 16'h010B, 1, 2);
    op(1, 0, 1, 0, 16'h0, 3'b000, 16'h010C, 0, 2);

    repeat (3) @(negedge clk);
    #1;
    n_assert++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard t=%0t: %0d expectations never compared", $time, sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_prog_thresh.md
# fifo_prog_thresh

Parametrised synchronous FIFO with run-time programmable almost-full/almost-empty thresholds, registered handshake status (wr_ack, overflow, underflow) and a clearable high-water-mark counter. It is the next-generation data buffer for the FIFO verification environment. It supports any depth ≥ 2, including non-power-of-two. An embedded assertion checker can be compiled in.

## Interface
- FIFO_WIDTH, 16, data word width in bits.
- FIFO_DEPTH, 8, number of entries; any value ≥ 2.
- CW (derived, not overridable), $clog2(FIFO_DEPTH)+1, width of count, thresholds and high-water mark.

Ports:
- clk  in  1  single clock, rising-edge active.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  FIFO_WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- af_thresh  in  CW  almost-full threshold, in entries.
- ae_thresh  in  CW  almost-empty threshold, in entries.
- hwm_clr  in  1  synchronous clear of the high-water mark.
- data_out  out  FIFO_WIDTH  registered read data.
- wr_ack  out  1  registered; write accepted last edge.
- overflow  out  1  registered; write rejected last edge.
- underflow  out  1  registered; read rejected last edge.
- full, empty, almostfull, almostempty  out  1 each  combinational from count.
- count  out  CW  current occupancy, 0..FIFO_DEPTH.
- hwm  out  CW  peak count since reset or last clear.

## Operation
- Write is accepted when wr_en && !full. Read is accepted when rd_en && !empty.
- Simultaneous wr_en && rd_en:
  - Neither full nor empty: both accepted, count unchanged.
  - Full: read only; the write is rejected and overflow pulses.
  - Empty: write only; the read is rejected and underflow pulses.
- Count update: +1 on write-only, −1 on read-only, unchanged otherwise.
- wr_ptr and rd_ptr are $clog2(FIFO_DEPTH) bits wide. Each wraps from FIFO_DEPTH−1 to 0 by explicit compare, never by natural overflow.
- Flag definitions:
  - full = (count == FIFO_DEPTH).
  - empty = (count == 0).
  - almostfull = (count ≥ af_thresh) && !full.
  - almostempty = (count ≤ ae_thresh) && !empty.
- Threshold boundary values:
  - af_thresh ≥ FIFO_DEPTH: almostfull never asserts.
  - af_thresh = 0: almostfull asserts whenever the FIFO is not full.
  - ae_thresh = 0: almostempty never asserts.
- Thresholds are sampled combinationally, so a change takes effect immediately.
- hwm loads count_next whenever count_next > hwm.
- hwm_clr loads count_next regardless of hwm (clear has priority).
- Reset (asynchronous, may occur mid-operation):
  - Cleared to 0: pointers, count, hwm, data_out, wr_ack, overflow, underflow.
  - Storage array is not cleared.
  - Flags immediately read empty=1, full=0, almostfull=0, almostempty=0.

## Timing
- Write to readable: a word written at edge N is visible to rd_en at edge N+1. There is no fall-through.
- Read latency: data_out updates at the edge that accepts the read, with one-cycle latency from rd_en. It holds its value when no read is accepted.
- wr_ack, overflow and underflow are high for exactly the cycle following the evaluating edge.
- They repeat on every cycle the condition persists.
- Flags and count track the register state, changing on the same edge as count.
- Removal of reset is synchronous to clk. The first operation is accepted at the first rising edge with rst_n=1.

## Configuration
- FIFO_ASSERT_EN defined: fifo_prog_thresh_sva is instantiated inside the block. It checks:
  - flag equations;
  - overflow after full && wr_en, and underflow after empty && rd_en;
  - count stays within 0..FIFO_DEPTH;
  - count changes by at most ±1 per cycle;
  - hwm ≥ count.
- Each check has a matching cover. The checker is disabled during !rst_n.
- FIFO_ASSERT_EN undefined: no checker is instantiated. Datapath behaviour is cycle-identical.

## Structure
- Package fifo_pkg provides:
  - function cnt_w(depth) returning $clog2(depth)+1;
  - function ptr_w(depth) returning $clog2(depth);
  - typedef fifo_status_t, a packed struct {wr_ack, overflow, underflow}.
- Sub-module fifo_prog_thresh_sva: assertion checker. All its ports are inputs and mirror the FIFO ports.

## Test plan
- DEPTH=8: reset, write 8 words 0x0001..0x0008. Required: wr_ack 8×, full=1, count=8, hwm=8. A 9th write gives overflow=1 and count stays 8.
- From full: read 8. Required: data_out 0x0001..0x0008 in order, empty=1. A 9th read gives underflow=1 and data_out holds 0x0008.
- af_thresh=6, ae_thresh=2: fill one word at a time. Required: almostempty at count 1–2, almostfull at count 6–7, and neither flag at count 0 or 8.
- FIFO_DEPTH=5: perform 12 writes interleaved with 12 reads. Required: pointers wrap 4→0 and data order is preserved.
- Simultaneous rd_en && wr_en:
  - count=3: count stays 3, wr_ack=1.
  - Full: count goes 8→7, overflow=1.
  - Empty: count goes 0→1, underflow=1.
- Assert rst_n low mid-fill at count=5 between clock edges. Required: count, hwm and all registered outputs go to 0 immediately, and empty=1.
- hwm_clr after a peak of 7 at count=3. Required: hwm=3.
